// File: rtl/fuq_pkg.sv
// rtl/fuq_pkg.sv - shared types for the pipelined FU/issue-queue wrapper
package fuq_pkg;

    localparam int FUQ_ID_BITS  = 6;
    localparam int FUQ_PRN_BITS = 6;
    localparam int FUQ_MAX_OPS  = 3;

    typedef struct packed {
        logic [FUQ_ID_BITS-1:0]                    id;
        logic [31:0]                               instr;
        logic [63:0]                               pc;
        logic [FUQ_MAX_OPS-1:0][FUQ_PRN_BITS-1:0]  src_prn;
        logic [FUQ_MAX_OPS-1:0]                    src_valid;
        logic [FUQ_MAX_OPS-1:0]                    src_ready;
        logic [FUQ_MAX_OPS-1:0][FUQ_PRN_BITS-1:0]  dst_prn;
        logic [FUQ_MAX_OPS-1:0]                    dst_valid;
    } iq_entry_t;

    typedef struct packed {
        logic                                      valid;
        logic [FUQ_ID_BITS-1:0]                    id;
        logic [FUQ_MAX_OPS-1:0][FUQ_PRN_BITS-1:0]  dst_prn;
        logic [FUQ_MAX_OPS-1:0]                    dst_valid;
    } pipe_stage_t;

endpackage

// File: rtl/fuq_age_select.sv
// rtl/fuq_age_select.sv - oldest-ready pick over an age matrix
// age_i[j*QUEUE_SIZE+i] set means entry j is older than entry i.
module fuq_age_select #(
    parameter int QUEUE_SIZE = 8
) (
    input  logic [QUEUE_SIZE-1:0]            req_i,
    input  logic [QUEUE_SIZE*QUEUE_SIZE-1:0] age_i,
    output logic                             grant_valid_o,
    output logic [$clog2(QUEUE_SIZE)-1:0]    grant_idx_o
);

    logic [QUEUE_SIZE-1:0] beaten;

    always_comb begin
        beaten        = '0;
        grant_idx_o   = '0;
        grant_valid_o = |req_i;
        for (int i = 0; i < QUEUE_SIZE; i++) begin
            for (int j = 0; j < QUEUE_SIZE; j++) begin
                if (j != i && req_i[j] && age_i[j*QUEUE_SIZE+i]) begin
                    beaten[i] = 1'b1;
                end
            end
        end
        for (int i = 0; i < QUEUE_SIZE; i++) begin
            if (req_i[i] && !beaten[i]) begin
                grant_idx_o = ($clog2(QUEUE_SIZE))'(i);
            end
        end
    end

endmodule

// File: rtl/pipelined_fuq_wrap.sv
// rtl/pipelined_fuq_wrap.sv - issue queue + fixed-latency FU tracking wrapper
// Optional perf counters under FUQ_PERF_EN.
module pipelined_fuq_wrap
    import fuq_pkg::*;
#(
    parameter int INST_ID_BITS = FUQ_ID_BITS,
    parameter int PRN_BITS     = FUQ_PRN_BITS,
    parameter int MAX_OPERANDS = FUQ_MAX_OPS,
    parameter int FU_COUNT     = 4,
    parameter int FU_INDEX     = 2,
    parameter int QUEUE_SIZE   = 8,
    parameter int FU_LATENCY   = 3
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         inst_valid,
    output logic                                         queue_ready,
    input  logic [INST_ID_BITS-1:0]                      inst_id,
    input  logic [31:0]                                  raw_instr,
    input  logic [63:0]                                  instr_pc,
    input  logic [MAX_OPERANDS-1:0]                      prn_input_valid,
    input  logic [MAX_OPERANDS-1:0]                      prn_input_ready,
    input  logic [MAX_OPERANDS*PRN_BITS-1:0]             prn_input,
    input  logic [MAX_OPERANDS-1:0]                      prn_output_valid,
    input  logic [MAX_OPERANDS*PRN_BITS-1:0]             prn_output,
    input  logic [(FU_COUNT-1)*MAX_OPERANDS-1:0]         set_prn_ready,
    input  logic [(FU_COUNT-1)*MAX_OPERANDS*PRN_BITS-1:0] set_prn,
    output logic [MAX_OPERANDS-1:0]                      prf_read_enable,
    output logic [MAX_OPERANDS*PRN_BITS-1:0]             prf_read_prn,
    input  logic [MAX_OPERANDS*64-1:0]                   prf_op,
    output logic                                         fu_issue_valid,
    output logic [31:0]                                  fu_issue_instr,
    output logic [63:0]                                  fu_issue_pc,
    output logic [MAX_OPERANDS*64-1:0]                   fu_issue_op,
    output logic                                         fu_stall,
    input  logic [MAX_OPERANDS*64-1:0]                   fu_result,
    input  logic                                         wb_ready,
    output logic [MAX_OPERANDS*64-1:0]                   prf_write,
    output logic [MAX_OPERANDS-1:0]                      prf_write_enable,
    output logic [MAX_OPERANDS*PRN_BITS-1:0]             prf_write_prn,
    output logic [INST_ID_BITS-1:0]                      fu_out_inst_id,
    output logic                                         fu_out_valid,
    output logic [MAX_OPERANDS-1:0]                      own_set_prn_ready,
    output logic [MAX_OPERANDS*PRN_BITS-1:0]             own_set_prn
`ifdef FUQ_PERF_EN
    ,
    output logic [31:0]                                  perf_issue_count,
    output logic [31:0]                                  perf_stall_cycles,
    output logic [31:0]                                  perf_full_cycles
`endif
);

    localparam int QW  = $clog2(QUEUE_SIZE);
    localparam int WB  = FU_COUNT * MAX_OPERANDS;
    localparam int PRE = (FU_LATENCY > 1) ? FU_LATENCY - 2 : 0;

    iq_entry_t                       entries_q [QUEUE_SIZE];
    logic [QUEUE_SIZE-1:0]           valid_q;
    logic [QUEUE_SIZE*QUEUE_SIZE-1:0] age_q;
    pipe_stage_t                     pipe_q [FU_LATENCY];
    logic                            final_new_q;

    logic [WB-1:0]          wk_v;
    logic [WB*PRN_BITS-1:0] wk_p;
    logic [QUEUE_SIZE-1:0]  req;
    logic                   sel_v;
    logic [QW-1:0]          sel_idx;
    logic [QW-1:0]          free_idx;
    logic                   alloc;
    iq_entry_t              sel_e;
    iq_entry_t              new_e;
    pipe_stage_t            fin;
    pipe_stage_t            iss;

    function automatic logic woken(input logic [PRN_BITS-1:0] p,
                                   input logic [WB-1:0] v,
                                   input logic [WB*PRN_BITS-1:0] pb);
        woken = 1'b0;
        for (int b = 0; b < WB; b++) begin
            if (v[b] && pb[b*PRN_BITS +: PRN_BITS] == p) woken = 1'b1;
        end
    endfunction

    // Full wakeup bus: own slot at FU_INDEX, external FUs packed around it.
    always_comb begin
        wk_v = '0;
        wk_p = '0;
        for (int f = 0; f < FU_COUNT; f++) begin
            for (int s = 0; s < MAX_OPERANDS; s++) begin
                if (f == FU_INDEX) begin
                    wk_v[f*MAX_OPERANDS+s] = own_set_prn_ready[s];
                    wk_p[(f*MAX_OPERANDS+s)*PRN_BITS +: PRN_BITS] = own_set_prn[s*PRN_BITS +: PRN_BITS];
                end else begin
                    wk_v[f*MAX_OPERANDS+s] = set_prn_ready[(f-((f > FU_INDEX) ? 1 : 0))*MAX_OPERANDS+s];
                    wk_p[(f*MAX_OPERANDS+s)*PRN_BITS +: PRN_BITS] =
                        set_prn[((f-((f > FU_INDEX) ? 1 : 0))*MAX_OPERANDS+s)*PRN_BITS +: PRN_BITS];
                end
            end
        end
    end

    always_comb begin
        free_idx = '0;
        for (int q = QUEUE_SIZE - 1; q >= 0; q--) begin
            if (!valid_q[q]) free_idx = QW'(q);
        end
        for (int q = 0; q < QUEUE_SIZE; q++) begin
            req[q] = valid_q[q] & (&entries_q[q].src_ready);
        end
        new_e.id        = inst_id;
        new_e.instr     = raw_instr;
        new_e.pc        = instr_pc;
        new_e.src_prn   = prn_input;
        new_e.src_valid = prn_input_valid;
        new_e.dst_prn   = prn_output;
        new_e.dst_valid = prn_output_valid;
        for (int s = 0; s < MAX_OPERANDS; s++) begin
            new_e.src_ready[s] = !prn_input_valid[s] | prn_input_ready[s] |
                                 woken(prn_input[s*PRN_BITS +: PRN_BITS], wk_v, wk_p);
        end
    end

    fuq_age_select #(.QUEUE_SIZE(QUEUE_SIZE)) u_sel (
        .req_i        (req & {QUEUE_SIZE{!fu_stall}}),
        .age_i        (age_q),
        .grant_valid_o(sel_v),
        .grant_idx_o  (sel_idx)
    );

    assign queue_ready = ~&valid_q;
    assign alloc       = inst_valid & queue_ready;
    assign sel_e       = entries_q[sel_idx];
    assign fin         = pipe_q[FU_LATENCY-1];

    assign fu_issue_valid  = sel_v;
    assign fu_issue_instr  = sel_e.instr;
    assign fu_issue_pc     = sel_e.pc;
    assign fu_issue_op     = prf_op;
    assign prf_read_enable = sel_v ? sel_e.src_valid : '0;
    assign prf_read_prn    = sel_e.src_prn;

    assign iss.valid     = sel_v;
    assign iss.id        = sel_e.id;
    assign iss.dst_prn   = sel_e.dst_prn;
    assign iss.dst_valid = sel_e.dst_valid;

    assign fu_stall          = fin.valid & ~wb_ready;
    assign fu_out_valid      = fin.valid & wb_ready;
    assign fu_out_inst_id    = fin.id;
    assign prf_write         = fu_result;
    assign prf_write_enable  = fin.dst_valid & {MAX_OPERANDS{fu_out_valid}};
    assign prf_write_prn     = fin.dst_prn;
    // Broadcast only on the first cycle in the final stage, never while held.
    assign own_set_prn_ready = fin.dst_valid & {MAX_OPERANDS{fin.valid & final_new_q}};
    assign own_set_prn       = fin.dst_prn;

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q     <= '0;
            age_q       <= '0;
            final_new_q <= 1'b0;
            for (int k = 0; k < FU_LATENCY; k++) pipe_q[k] <= '0;
        end else begin
            for (int q = 0; q < QUEUE_SIZE; q++) begin
                for (int s = 0; s < MAX_OPERANDS; s++) begin
                    if (valid_q[q] && entries_q[q].src_valid[s] && !entries_q[q].src_ready[s] &&
                        woken(entries_q[q].src_prn[s], wk_v, wk_p)) begin
                        entries_q[q].src_ready[s] <= 1'b1;
                    end
                end
            end
            if (sel_v) valid_q[sel_idx] <= 1'b0;
            if (alloc) begin
                valid_q[free_idx]   <= 1'b1;
                entries_q[free_idx] <= new_e;
                for (int j = 0; j < QUEUE_SIZE; j++) begin
                    age_q[j*QUEUE_SIZE+int'(free_idx)] <= 1'b1;
                    age_q[int'(free_idx)*QUEUE_SIZE+j] <= 1'b0;
                end
            end
            if (!fu_stall) begin
                pipe_q[0] <= iss;
                for (int k = 1; k < FU_LATENCY; k++) pipe_q[k] <= pipe_q[k-1];
                final_new_q <= (FU_LATENCY == 1) ? sel_v : pipe_q[PRE].valid;
            end else begin
                final_new_q <= 1'b0;
            end
        end
    end

`ifdef FUQ_PERF_EN
    logic [31:0] perf_issue_q, perf_stall_q, perf_full_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_issue_q <= '0;
            perf_stall_q <= '0;
            perf_full_q  <= '0;
        end else begin
            if (sel_v && ~&perf_issue_q)        perf_issue_q <= perf_issue_q + 32'd1;
            if (fu_stall && ~&perf_stall_q)     perf_stall_q <= perf_stall_q + 32'd1;
            if (!queue_ready && ~&perf_full_q)  perf_full_q  <= perf_full_q + 32'd1;
        end
    end

    assign perf_issue_count  = perf_issue_q;
    assign perf_stall_cycles = perf_stall_q;
    assign perf_full_cycles  = perf_full_q;
`endif

endmodule

// File: tb/tb_pipelined_fuq_wrap.sv
// tb/tb_pipelined_fuq_wrap.sv - directed and randomized checks for pipelined_fuq_wrap
module tb_pipelined_fuq_wrap;

    localparam int LAT = 3;
    localparam int NRND = 40;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         inst_valid;
    logic         queue_ready;
    logic [5:0]   inst_id;
    logic [31:0]  raw_instr;
    logic [63:0]  instr_pc;
    logic [2:0]   prn_input_valid, prn_input_ready, prn_output_valid;
    logic [17:0]  prn_input, prn_output;
    logic [8:0]   set_prn_ready;
    logic [53:0]  set_prn;
    logic [2:0]   prf_read_enable;
    logic [17:0]  prf_read_prn;
    logic [191:0] prf_op;
    logic         fu_issue_valid;
    logic [31:0]  fu_issue_instr;
    logic [63:0]  fu_issue_pc;
    logic [191:0] fu_issue_op;
    logic         fu_stall;
    logic [191:0] fu_result;
    logic         wb_ready;
    logic [191:0] prf_write;
    logic [2:0]   prf_write_enable;
    logic [17:0]  prf_write_prn;
    logic [5:0]   fu_out_inst_id;
    logic         fu_out_valid;
    logic [2:0]   own_set_prn_ready;
    logic [17:0]  own_set_prn;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    pipelined_fuq_wrap dut (
        .clk(clk), .rst(rst), .inst_valid(inst_valid), .queue_ready(queue_ready),
        .inst_id(inst_id), .raw_instr(raw_instr), .instr_pc(instr_pc),
        .prn_input_valid(prn_input_valid), .prn_input_ready(prn_input_ready), .prn_input(prn_input),
        .prn_output_valid(prn_output_valid), .prn_output(prn_output),
        .set_prn_ready(set_prn_ready), .set_prn(set_prn),
        .prf_read_enable(prf_read_enable), .prf_read_prn(prf_read_prn), .prf_op(prf_op),
        .fu_issue_valid(fu_issue_valid), .fu_issue_instr(fu_issue_instr), .fu_issue_pc(fu_issue_pc),
        .fu_issue_op(fu_issue_op), .fu_stall(fu_stall), .fu_result(fu_result), .wb_ready(wb_ready),
        .prf_write(prf_write), .prf_write_enable(prf_write_enable), .prf_write_prn(prf_write_prn),
        .fu_out_inst_id(fu_out_inst_id), .fu_out_valid(fu_out_valid),
        .own_set_prn_ready(own_set_prn_ready), .own_set_prn(own_set_prn)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle();
        inst_valid = 1'b0; inst_id = '0; raw_instr = '0; instr_pc = '0;
        prn_input_valid = '0; prn_input_ready = '0; prn_input = '0;
        prn_output_valid = '0; prn_output = '0;
        set_prn_ready = '0; set_prn = '0;
    endtask

    task automatic do_reset();
        idle();
        wb_ready = 1'b1;
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic put_inst(input logic [5:0] id, input logic [31:0] ins,
                            input logic [2:0] sv, input logic [2:0] sr, input logic [17:0] sp,
                            input logic [2:0] dv, input logic [17:0] dp);
        inst_valid = 1'b1; inst_id = id; raw_instr = ins; instr_pc = {32'h0, ins};
        prn_input_valid = sv; prn_input_ready = sr; prn_input = sp;
        prn_output_valid = dv; prn_output = dp;
    endtask

    typedef struct {
        logic [5:0]  id;
        logic [2:0]  dv;
        logic [17:0] dp;
    } exp_t;

    exp_t sb[$];

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [17:0] sp, dp;
        logic [31:0] ia, ib;
        int a_iss, bc, bi, k, sent, done;
        exp_t e;

        prf_op = '0; fu_result = '0;
        do_reset();

        // Reset state
        chk("rst_queue_ready", 64'(queue_ready), 64'(1));
        chk("rst_issue_valid", 64'(fu_issue_valid), 64'(0));
        chk("rst_stall", 64'(fu_stall), 64'(0));
        chk("rst_out_valid", 64'(fu_out_valid), 64'(0));
        chk("rst_rd_en", 64'(prf_read_enable), 64'(0));
        chk("rst_wr_en", 64'(prf_write_enable), 64'(0));
        chk("rst_own_bcast", 64'(own_set_prn_ready), 64'(0));

        // 1: single ready instruction through the pipeline
        sp = 18'($urandom); dp = 18'($urandom); ia = $urandom;
        put_inst(6'd5, ia, 3'b011, 3'b011, sp, 3'b101, dp);
        tick();
        inst_valid = 1'b0;
        prf_op = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        #1;
        chk("t1_issue_valid", 64'(fu_issue_valid), 64'(1));
        chk("t1_issue_instr", 64'(fu_issue_instr), 64'(ia));
        chk("t1_rd_en", 64'(prf_read_enable), 64'(3'b011));
        chk("t1_rd_prn", 64'(prf_read_prn), 64'(sp));
        chk("t1_issue_op", fu_issue_op[127:64], prf_op[127:64]);
        tick();
        chk("t1_single_issue", 64'(fu_issue_valid), 64'(0));
        chk("t1_no_early_out", 64'(fu_out_valid), 64'(0));
        tick();
        tick();
        fu_result = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        #1;
        chk("t1_out_valid", 64'(fu_out_valid), 64'(1));
        chk("t1_out_id", 64'(fu_out_inst_id), 64'(5));
        chk("t1_wr_en", 64'(prf_write_enable), 64'(3'b101));
        chk("t1_wr_prn", 64'(prf_write_prn), 64'(dp));
        chk("t1_wr_data", prf_write[191:128], fu_result[191:128]);
        chk("t1_own_bcast", 64'(own_set_prn_ready), 64'(3'b101));
        tick();
        chk("t1_out_done", 64'(fu_out_valid), 64'(0));
        chk("t1_bcast_once", 64'(own_set_prn_ready), 64'(0));

        // 2: dependant wakes from own broadcast
        do_reset();
        ia = $urandom; ib = ia ^ 32'h1;
        put_inst(6'd7, ia, 3'b000, 3'b000, 18'd0, 3'b001, 18'd10);
        tick();
        a_iss = cyc;
        put_inst(6'd8, ib, 3'b001, 3'b000, 18'd10, 3'b000, 18'd0);
        tick();
        inst_valid = 1'b0;
        bc = -1; bi = -1;
        for (int n = 0; n < 12; n++) begin
            if (own_set_prn_ready[0] && own_set_prn[5:0] == 6'd10 && bc < 0) bc = cyc;
            if (fu_issue_valid && fu_issue_instr == ib && bi < 0) bi = cyc;
            tick();
        end
        chk("t2_bcast_cycle", 64'(bc), 64'(a_iss + LAT));
        chk("t2_dep_issue", 64'(bi), 64'(a_iss + LAT + 1));

        // 3: fill the queue, wake one entry through an external FU slot
        do_reset();
        for (int i = 0; i < 8; i++) begin
            put_inst(6'(16 + i), 32'h100 + i, 3'b001, 3'b000, 18'(20 + i), 3'b000, 18'd0);
            if (i == 7) chk("t3_ready_at_7", 64'(queue_ready), 64'(1));
            tick();
        end
        inst_valid = 1'b0;
        chk("t3_full", 64'(queue_ready), 64'(0));
        chk("t3_none_ready", 64'(fu_issue_valid), 64'(0));
        k = $urandom_range(0, 7);
        set_prn_ready[2*3+1] = 1'b1;
        set_prn[(2*3+1)*6 +: 6] = 6'(20 + k);
        tick();
        set_prn_ready = '0;
        chk("t3_wake_issue", 64'(fu_issue_valid), 64'(1));
        chk("t3_wake_instr", 64'(fu_issue_instr), 64'(32'h100 + k));
        chk("t3_still_full", 64'(queue_ready), 64'(0));
        tick();
        chk("t3_freed", 64'(queue_ready), 64'(1));
        chk("t3_no_more", 64'(fu_issue_valid), 64'(0));

        // 4: age order beats slot order; allocation-cycle bypass
        do_reset();
        put_inst(6'd1, 32'hF, 3'b000, 3'b000, 18'd0, 3'b000, 18'd0);
        tick();
        ia = $urandom; ib = ia ^ 32'h2;
        put_inst(6'd3, ia, 3'b001, 3'b000, 18'd30, 3'b000, 18'd0);
        tick();
        put_inst(6'd4, ib, 3'b001, 3'b000, 18'd30, 3'b000, 18'd0);
        tick();
        inst_valid = 1'b0;
        chk("t4_waiting", 64'(fu_issue_valid), 64'(0));
        set_prn_ready[0] = 1'b1;
        set_prn[5:0] = 6'd30;
        tick();
        set_prn_ready = '0;
        chk("t4_first_valid", 64'(fu_issue_valid), 64'(1));
        chk("t4_first_is_id3", 64'(fu_issue_instr), 64'(ia));
        tick();
        chk("t4_second_valid", 64'(fu_issue_valid), 64'(1));
        chk("t4_second_is_id4", 64'(fu_issue_instr), 64'(ib));
        put_inst(6'd9, 32'h99, 3'b100, 3'b000, {6'd33, 12'd0}, 3'b000, 18'd0);
        set_prn_ready[1*3+2] = 1'b1;
        set_prn[(1*3+2)*6 +: 6] = 6'd33;
        tick();
        idle();
        chk("t4_bypass_issue", 64'(fu_issue_valid), 64'(1));
        chk("t4_bypass_instr", 64'(fu_issue_instr), 64'(32'h99));

        // 5: writeback backpressure
        do_reset();
        dp = 18'($urandom); ia = $urandom; ib = ia ^ 32'h4;
        put_inst(6'd12, ia, 3'b000, 3'b000, 18'd0, 3'b010, dp);
        tick();
        inst_valid = 1'b0;
        wb_ready = 1'b0;
        tick();
        tick();
        put_inst(6'd13, ib, 3'b000, 3'b000, 18'd0, 3'b000, 18'd0);
        tick();
        inst_valid = 1'b0;
        #1;
        chk("t5_stall", 64'(fu_stall), 64'(1));
        chk("t5_bcast", 64'(own_set_prn_ready), 64'(3'b010));
        chk("t5_no_wb", 64'(prf_write_enable), 64'(0));
        chk("t5_no_out", 64'(fu_out_valid), 64'(0));
        chk("t5_no_issue", 64'(fu_issue_valid), 64'(0));
        for (int s = 0; s < 3; s++) begin
            tick();
            chk("t5_hold", 64'({fu_stall, own_set_prn_ready, fu_out_valid, fu_issue_valid}),
                64'({1'b1, 3'b000, 1'b0, 1'b0}));
        end
        tick();
        wb_ready = 1'b1;
        #1;
        chk("t5_release_stall", 64'(fu_stall), 64'(0));
        chk("t5_release_out", 64'(fu_out_valid), 64'(1));
        chk("t5_release_id", 64'(fu_out_inst_id), 64'(12));
        chk("t5_release_wr_en", 64'(prf_write_enable), 64'(3'b010));
        chk("t5_release_issue", 64'(fu_issue_instr), 64'(ib));
        tick();
        chk("t5_single_wb", 64'(fu_out_valid), 64'(0));

        // 6: reset with work in flight
        do_reset();
        for (int i = 0; i < 3; i++) begin
            put_inst(6'(40 + i), 32'h200 + i, 3'b000, 3'b000, 18'd0, 3'b001, 18'(50 + i));
            tick();
        end
        put_inst(6'd44, 32'h300, 3'b001, 3'b000, 18'd40, 3'b000, 18'd0);
        tick();
        idle();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("t6_queue_ready", 64'(queue_ready), 64'(1));
        chk("t6_valids", 64'({fu_issue_valid, fu_stall, fu_out_valid, prf_read_enable,
                              prf_write_enable, own_set_prn_ready}), 64'(0));
        for (int n = 0; n < 6; n++) begin
            tick();
            chk("t6_quiet", 64'({fu_out_valid, fu_issue_valid}), 64'(0));
        end

        // Random: all-ready traffic completes in dispatch order under random backpressure
        do_reset();
        sent = 0; done = 0;
        for (int n = 0; n < 3000 && done < NRND; n++) begin
            inst_valid = 1'b0;
            wb_ready = ($urandom_range(0, 9) < 7);
            if (sent < NRND && queue_ready && $urandom_range(0, 1) == 1) begin
                e.id = 6'(sent);
                e.dv = 3'($urandom);
                e.dp = 18'($urandom);
                sp = 18'($urandom);
                k = $urandom_range(0, 7);
                put_inst(e.id, $urandom, 3'(k), 3'(k), sp, e.dv, e.dp);
                sb.push_back(e);
                sent++;
            end
            #1;
            if (fu_out_valid) begin
                if (sb.size() == 0) begin
                    chk("rnd_spurious_out", 64'(1), 64'(0));
                end else begin
                    e = sb.pop_front();
                    chk("rnd_out_id", 64'(fu_out_inst_id), 64'(e.id));
                    chk("rnd_wr_en", 64'(prf_write_enable), 64'(e.dv));
                    chk("rnd_wr_prn", 64'(prf_write_prn), 64'(e.dp));
                end
                done++;
            end
            tick();
        end
        chk("rnd_all_done", 64'(done), 64'(NRND));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
